// File: rtl/reflet_vga_fb_ctrl.sv
// Bus-mapped pixel writer for a small VGA framebuffer: H/V/COLOR/CTRL/STATUS registers,
// a pixel FIFO and a vblank interrupt. Define REFLET_VGA_FILL_EN to build the screen-fill engine.
module reflet_vga_fb_ctrl #(
  parameter int base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr = 16'hFF24,
  parameter int h_pixels = 160,
  parameter int v_pixels = 120,
  parameter int color_bits = 6,
  parameter int fifo_depth = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [base_addr_size-1:0]     addr,
  input  logic [7:0]                    data_in,
  output logic [7:0]                    data_out,
  input  logic                          write_en,
  input  logic                          v_sync_in,
  output logic                          interrupt,
  output logic                          fb_we,
  input  logic                          fb_ready,
  output logic [$clog2(h_pixels)-1:0]   fb_h,
  output logic [$clog2(v_pixels)-1:0]   fb_v,
  output logic [color_bits-1:0]         fb_color
);
  localparam int HW = $clog2(h_pixels);
  localparam int VW = $clog2(v_pixels);
  localparam int PW = $clog2(fifo_depth);
  localparam int EW = HW + VW + color_bits;
  localparam logic [7:0] H_LAST = 8'(h_pixels - 1);
  localparam logic [7:0] V_LAST = 8'(v_pixels - 1);
  localparam logic [PW:0] FIFO_FULL = (PW + 1)'(fifo_depth);

  logic [base_addr_size-1:0] offset_s;
  logic hit_s, wr_h_s, wr_v_s, wr_color_s, wr_ctrl_s, wr_status_s;
  logic fifo_empty_s, fifo_full_s, push_s, pop_s, vsync_rise_s;
  logic fill_busy_s, fill_active_s;
  logic [HW-1:0] fill_h_s;
  logic [VW-1:0] fill_v_s;
  logic [color_bits-1:0] fill_color_s;
  logic [EW-1:0] head_s;

  logic [7:0] h_q, h_d, v_q, v_d;
  logic [color_bits-1:0] color_q, color_d;
  logic auto_inc_q, auto_inc_d, irq_en_q, irq_en_d;
  logic overflow_q, overflow_d, vblank_q, vblank_d;
  logic [1:0] sync_q, sync_d;
  logic vs_prev_q, vs_prev_d;

  logic [EW-1:0] mem_q [fifo_depth];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;

  assign offset_s    = addr - base_addr;
  assign hit_s       = enable && (offset_s < base_addr_size'(5));
  assign wr_h_s      = hit_s && write_en && (offset_s[2:0] == 3'd0);
  assign wr_v_s      = hit_s && write_en && (offset_s[2:0] == 3'd1);
  assign wr_color_s  = hit_s && write_en && (offset_s[2:0] == 3'd2);
  assign wr_ctrl_s   = hit_s && write_en && (offset_s[2:0] == 3'd3);
  assign wr_status_s = hit_s && write_en && (offset_s[2:0] == 3'd4);

  assign fifo_empty_s = (count_q == '0);
  assign fifo_full_s  = (count_q == FIFO_FULL);
  assign fb_we        = !fifo_empty_s || fill_active_s;
  assign pop_s        = fb_ready && !fifo_empty_s && !fill_active_s;
  // A full FIFO still takes a new pixel when the head leaves in the same cycle
  assign push_s       = wr_color_s && !fill_busy_s && (!fifo_full_s || pop_s);
  assign vsync_rise_s = sync_q[1] && !vs_prev_q;
  assign interrupt    = vblank_q && irq_en_q;
  assign head_s       = mem_q[rd_ptr_q];

  // Register read mux
  always_comb begin
    data_out = 8'h00;
    if (hit_s) begin
      case (offset_s[2:0])
        3'd0:    data_out = h_q;
        3'd1:    data_out = v_q;
        3'd2:    data_out = 8'(color_q);
        3'd3:    data_out = {6'b000000, irq_en_q, auto_inc_q};
        3'd4:    data_out = {3'b000, overflow_q, vblank_q, fill_busy_s, fifo_empty_s, fifo_full_s};
        default: data_out = 8'h00;
      endcase
    end else begin
      data_out = 8'h00;
    end
  end

  // Pixel port source: fill engine while it runs, otherwise the FIFO head
  always_comb begin
    if (fill_active_s) begin
      fb_h     = fill_h_s;
      fb_v     = fill_v_s;
      fb_color = fill_color_s;
    end else begin
      fb_h     = head_s[EW-1 -: HW];
      fb_v     = head_s[color_bits +: VW];
      fb_color = head_s[color_bits-1:0];
    end
  end

  // Register next-state logic
  always_comb begin
    h_d        = h_q;
    v_d        = v_q;
    color_d    = color_q;
    auto_inc_d = auto_inc_q;
    irq_en_d   = irq_en_q;
    overflow_d = overflow_q;
    vblank_d   = vblank_q;
    sync_d     = {sync_q[0], v_sync_in};
    vs_prev_d  = sync_q[1];
    if (wr_h_s) begin
      h_d = (data_in > H_LAST) ? H_LAST : data_in;
    end else if (wr_v_s) begin
      v_d = (data_in > V_LAST) ? V_LAST : data_in;
    end else if (push_s && auto_inc_q) begin
      if (h_q == H_LAST) begin
        h_d = 8'h00;
        v_d = (v_q == V_LAST) ? 8'h00 : v_q + 8'h01;
      end else begin
        h_d = h_q + 8'h01;
      end
    end else begin
      h_d = h_q;
      v_d = v_q;
    end
    if (push_s) begin
      color_d = data_in[color_bits-1:0];
    end else begin
      color_d = color_q;
    end
    if (wr_ctrl_s) begin
      auto_inc_d = data_in[0];
      irq_en_d   = data_in[1];
    end else begin
      auto_inc_d = auto_inc_q;
      irq_en_d   = irq_en_q;
    end
    if (wr_color_s && !push_s) begin
      overflow_d = 1'b1;
    end else if (wr_status_s && data_in[4]) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (vsync_rise_s) begin
      vblank_d = 1'b1;
    end else if (wr_status_s && data_in[3]) begin
      vblank_d = 1'b0;
    end else begin
      vblank_d = vblank_q;
    end
  end

  // Register state
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q        <= 8'h00;
      v_q        <= 8'h00;
      color_q    <= '0;
      auto_inc_q <= 1'b0;
      irq_en_q   <= 1'b0;
      overflow_q <= 1'b0;
      vblank_q   <= 1'b0;
      sync_q     <= 2'b00;
      vs_prev_q  <= 1'b0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      color_q    <= color_d;
      auto_inc_q <= auto_inc_d;
      irq_en_q   <= irq_en_d;
      overflow_q <= overflow_d;
      vblank_q   <= vblank_d;
      sync_q     <= sync_d;
      vs_prev_q  <= vs_prev_d;
    end
  end

  // Pixel FIFO; storage is cleared on reset so the pixel port idles at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < fifo_depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= {h_q[HW-1:0], v_q[VW-1:0], data_in[color_bits-1:0]};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + (PW + 1)'(1);
        2'b01:   count_q <= count_q - (PW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef REFLET_VGA_FILL_EN
  typedef enum logic [1:0] {FILL_IDLE = 2'd0, FILL_DRAIN = 2'd1, FILL_RUN = 2'd2} fill_state_e;
  localparam logic [HW-1:0] FH_LAST = HW'(h_pixels - 1);
  localparam logic [VW-1:0] FV_LAST = VW'(v_pixels - 1);
  fill_state_e fill_state_q;
  logic [HW-1:0] fill_h_q;
  logic [VW-1:0] fill_v_q;
  logic [color_bits-1:0] fill_color_q;

  // Fill engine: wait for queued pixels to drain, then raster the whole screen
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_state_q <= FILL_IDLE;
      fill_h_q     <= '0;
      fill_v_q     <= '0;
      fill_color_q <= '0;
    end else begin
      case (fill_state_q)
        FILL_IDLE: begin
          if (wr_ctrl_s && data_in[2]) begin
            fill_state_q <= FILL_DRAIN;
          end
        end
        FILL_DRAIN: begin
          if (fifo_empty_s) begin
            fill_state_q <= FILL_RUN;
            fill_h_q     <= '0;
            fill_v_q     <= '0;
            fill_color_q <= color_q;
          end
        end
        FILL_RUN: begin
          if (fb_ready) begin
            if (fill_h_q == FH_LAST) begin
              fill_h_q <= '0;
              if (fill_v_q == FV_LAST) begin
                fill_v_q     <= '0;
                fill_state_q <= FILL_IDLE;
              end else begin
                fill_v_q <= fill_v_q + VW'(1);
              end
            end else begin
              fill_h_q <= fill_h_q + HW'(1);
            end
          end
        end
        default: fill_state_q <= FILL_IDLE;
      endcase
    end
  end

  assign fill_busy_s   = (fill_state_q != FILL_IDLE);
  assign fill_active_s = (fill_state_q == FILL_RUN);
  assign fill_h_s      = fill_h_q;
  assign fill_v_s      = fill_v_q;
  assign fill_color_s  = fill_color_q;
`else
  assign fill_busy_s   = 1'b0;
  assign fill_active_s = 1'b0;
  assign fill_h_s      = '0;
  assign fill_v_s      = '0;
  assign fill_color_s  = '0;
`endif

endmodule

// File: tb/tb_reflet_vga_fb_ctrl.sv
// Randomised and directed bench for reflet_vga_fb_ctrl against a queue-based model of
// the register file and pixel stream. Fill-engine checks build when REFLET_VGA_FILL_EN is set.
module tb_reflet_vga_fb_ctrl;
  localparam logic [15:0] BASE = 16'hFF24;

  logic clk = 1'b0;
  logic reset, enable, write_en, v_sync_in, fb_ready;
  logic [15:0] addr;
  logic [7:0] data_in, data_out;
  logic interrupt, fb_we;
  logic [7:0] fb_h;
  logic [6:0] fb_v;
  logic [5:0] fb_color;

  always #5 clk = ~clk;

  reflet_vga_fb_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr),
    .data_in(data_in), .data_out(data_out), .write_en(write_en),
    .v_sync_in(v_sync_in), .interrupt(interrupt),
    .fb_we(fb_we), .fb_ready(fb_ready), .fb_h(fb_h), .fb_v(fb_v), .fb_color(fb_color)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct { int h; int v; int c; } pix_t;
  pix_t exp_q[$];
  int m_h, m_v, m_color, m_auto, m_irq, m_ovf, m_vbl;
  logic [7:0] rd_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] model_read(input int off);
    case (off)
      0: return 8'(m_h);
      1: return 8'(m_v);
      2: return 8'(m_color);
      3: return 8'(m_irq * 2 + m_auto);
      4: return 8'(m_ovf * 16 + m_vbl * 8 + (exp_q.size() == 0 ? 2 : 0) + (exp_q.size() == 4 ? 1 : 0));
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_h = 0; m_v = 0; m_color = 0; m_auto = 0; m_irq = 0; m_ovf = 0; m_vbl = 0;
  endtask

  // One bus cycle, entered and left just after a falling edge
  task automatic step(input bit en, input bit we, input int off, input int data, input bit rdy);
    pix_t p;
    bit popped;
    int idx;
    enable = en; write_en = we; addr = BASE + 16'(off); data_in = 8'(data); fb_ready = rdy;
    #1;
    rd_last = data_out;
    check("data_out", 32'(data_out), 32'(en ? model_read(off) : 8'h00));
    check("fb_we", 32'(fb_we), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("fb_h", 32'(fb_h), exp_q[0].h);
      check("fb_v", 32'(fb_v), exp_q[0].v);
      check("fb_color", 32'(fb_color), exp_q[0].c);
    end
    check("interrupt", 32'(interrupt), 32'(m_vbl & m_irq));
    popped = rdy && (exp_q.size() != 0);
    if (en && we) begin
      case (off)
        0: m_h = (data >= 160) ? 159 : data;
        1: m_v = (data >= 120) ? 119 : data;
        2: begin
          if (exp_q.size() < 4 || popped) begin
            p.h = m_h; p.v = m_v; p.c = data % 64;
            exp_q.push_back(p);
            m_color = data % 64;
            if (m_auto != 0) begin
              idx = (m_v * 160 + m_h + 1) % 19200;
              m_h = idx % 160;
              m_v = idx / 160;
            end
          end else begin
            m_ovf = 1;
          end
        end
        3: begin m_auto = data % 2; m_irq = (data / 2) % 2; end
        4: begin
          if (((data / 8) % 2) != 0) m_vbl = 0;
          if (((data / 16) % 2) != 0) m_ovf = 0;
        end
        default: ;
      endcase
    end
    if (popped) void'(exp_q.pop_front());
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int got;
    reset = 1'b1; enable = 1'b0; write_en = 1'b0; v_sync_in = 1'b0; fb_ready = 1'b0;
    addr = BASE; data_in = 8'h00;
    @(posedge clk);
    @(negedge clk);
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_irq", 32'(interrupt), 32'd0);
    check("rst_fb_pix", {8'h00, fb_h, 1'b0, fb_v, 2'b00, fb_color}, 32'd0);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, i, 0, 1'b0);
      check("rst_reg", 32'(rd_last), (i == 4) ? 32'h02 : 32'h00);
    end

    // Single pixel
    step(1'b1, 1'b1, 0, 5, 1'b1);
    step(1'b1, 1'b1, 1, 7, 1'b1);
    step(1'b1, 1'b1, 2, 8'h2A, 1'b1);
    check("px_we", 32'(fb_we), 32'd1);
    check("px_pos", {16'h0, fb_h, 1'b0, fb_v}, {16'h0, 8'd5, 8'd7});
    check("px_color", 32'(fb_color), 32'h2A);
    step(1'b1, 1'b0, 4, 0, 1'b1);
    step(1'b1, 1'b0, 4, 0, 1'b1);
    check("px_status", 32'(rd_last), 32'h02);

    // Auto-increment wrap at the last pixel
    step(1'b1, 1'b1, 3, 1, 1'b1);
    step(1'b1, 1'b1, 0, 159, 1'b1);
    step(1'b1, 1'b1, 1, 119, 1'b1);
    step(1'b1, 1'b1, 2, 8'h11, 1'b0);
    step(1'b1, 1'b1, 2, 8'h22, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 1'b1);
    check("wrap_h", 32'(rd_last), 32'd1);
    step(1'b1, 1'b0, 1, 0, 1'b1);
    check("wrap_v", 32'(rd_last), 32'd0);

    // Overflow with a stalled framebuffer
    step(1'b1, 1'b1, 3, 0, 1'b1);
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 2, i, 1'b0);
    step(1'b1, 1'b0, 4, 0, 1'b0);
    check("ovf_status", 32'(rd_last), 32'h11);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4, 0, 1'b1);
    step(1'b1, 1'b1, 4, 8'h10, 1'b1);

    // Clamp
    step(1'b1, 1'b1, 0, 200, 1'b1);
    step(1'b1, 1'b0, 0, 0, 1'b1);
    check("clamp_h", 32'(rd_last), 32'd159);

`ifndef REFLET_VGA_FILL_EN
    step(1'b1, 1'b1, 3, 8'h07, 1'b1);
    step(1'b1, 1'b0, 3, 0, 1'b1);
    check("ctrl_nofill", 32'(rd_last), 32'h03);
    step(1'b1, 1'b0, 4, 0, 1'b1);
    check("busy_nofill", 32'(rd_last[2]), 32'd0);
    step(1'b1, 1'b1, 3, 0, 1'b1);
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      int off, data;
      off = $urandom_range(0, 6);
      if ($urandom_range(0, 2) == 0) off = 2;
      data = $urandom_range(0, 255);
      if (off == 3) data = data % 4;
      step($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, off, data, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4, 0, 1'b1);

    // vblank interrupt
    step(1'b1, 1'b1, 3, 2, 1'b1);
    step(1'b1, 1'b1, 4, 8'h18, 1'b1);
    v_sync_in = 1'b1; enable = 1'b0; write_en = 1'b0;
    got = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (interrupt) got = 1;
    end
    check("irq_rise", 32'(got), 32'd1);
    m_vbl = 1;
    v_sync_in = 1'b0;
    step(1'b1, 1'b0, 4, 0, 1'b1);
    step(1'b1, 1'b1, 4, 8'h08, 1'b1);
    step(1'b1, 1'b0, 4, 0, 1'b1);
    check("irq_clear", 32'(interrupt), 32'd0);
    step(1'b1, 1'b1, 3, 0, 1'b1);

`ifdef REFLET_VGA_FILL_EN
    begin
      int nw, bad, busy_bad;
      step(1'b1, 1'b1, 2, 8'h15, 1'b1);
      step(1'b1, 1'b1, 3, 8'h04, 1'b1);
      nw = 0; bad = 0; busy_bad = 0;
      for (int c = 0; c < 23000 && nw < 19200; c++) begin
        enable = 1'b1; write_en = 1'b0; addr = BASE + 16'd4;
        fb_ready = ((c % 7) != 3);
        if (c == 300) begin write_en = 1'b1; addr = BASE + 16'd2; data_in = 8'h3F; end
        #1;
        if (c != 300 && data_out[2] !== 1'b1) busy_bad++;
        if (fb_we && fb_ready) begin
          if (int'(fb_h) != nw % 160 || int'(fb_v) != nw / 160 || fb_color != 6'h15) bad++;
          nw++;
        end
        @(posedge clk);
        @(negedge clk);
      end
      check("fill_count", 32'(nw), 32'd19200);
      check("fill_order", 32'(bad), 32'd0);
      check("fill_busy", 32'(busy_bad), 32'd0);
      m_ovf = 1;
      step(1'b1, 1'b0, 4, 0, 1'b1);
      check("fill_done", 32'(rd_last), 32'h12);
      step(1'b1, 1'b1, 4, 8'h10, 1'b1);
      step(1'b1, 1'b1, 3, 8'h04, 1'b1);
      enable = 1'b0; write_en = 1'b0; fb_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk);
        @(negedge clk);
      end
      check("fill_running", 32'(fb_we), 32'd1);
    end
`else
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, 2, i * 9, 1'b0);
`endif

    // Reset in the middle of an operation
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_we", 32'(fb_we), 32'd0);
    check("midrst_pix", {8'h00, fb_h, 1'b0, fb_v, 2'b00, fb_color}, 32'd0);
    reset = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 4, 0, 1'b1);
    check("midrst_status", 32'(rd_last), 32'h02);
    step(1'b1, 1'b0, 3, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
